// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared PRESENT-80 constants, nibble tables and bit permutations
//
// Purpose : Widths, round count, S-box tables and pLayer functions used by both
//           the encrypt and decrypt datapaths.
// Ports   : none (package)
package present_pkg;

    localparam int BLOCK_W    = 64;
    localparam int KEY_W      = 80;
    localparam int NUM_ROUNDS = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Phase is decoded from the round counter and done flag; no extra state flop.
    typedef enum logic [1:0] {
        PH_RUN,
        PH_FIN,
        PH_HOLD
    } phase_e;

    // Bit i moves to 16*i mod 63; bit 63 stays in place.
    function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        logic [5:0]         src;
        logic [5:0]         dst;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            src    = 6'(i);
            dst    = 6'((16 * i) % 63);
            y[dst] = x[src];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        logic [5:0]         src;
        logic [5:0]         dst;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            src    = 6'(i);
            dst    = 6'((16 * i) % 63);
            y[src] = x[dst];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present_if.sv
// rtl/present_if.sv - plaintext/key in, ciphertext/done out bundle for the PRESENT encryptor
//
// Purpose : Groups the data-side signals of present_encrypt.
// Signals : key  [79:0] cipher key (master -> slave)
//           msg  [63:0] plaintext  (master -> slave)
//           done        ciphertext valid (slave -> master)
//           enc  [63:0] ciphertext (slave -> master)
interface present_if;
    import present_pkg::*;

    logic [KEY_W-1:0]   key;
    logic [BLOCK_W-1:0] msg;
    logic               done;
    logic [BLOCK_W-1:0] enc;

    modport master (output key, output msg, input done, input enc);
    modport slave  (input key, input msg, output done, output enc);

endinterface

// File: rtl/present_sp_layer.sv
// rtl/present_sp_layer.sv - combinational PRESENT substitution layer followed by pLayer
//
// Purpose : Applies the 4-bit S-box to all 16 nibbles, then the bit permutation.
// Ports   : data_i [63:0] round input (already key-mixed)
//           data_o [63:0] round output
module present_sp_layer
    import present_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    logic [BLOCK_W-1:0] s_out;

    for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_sbox
        assign s_out[4*n +: 4] = SBOX[data_i[4*n +: 4]];
    end

    assign data_o = p_layer(s_out);

endmodule

// File: rtl/present_encrypt.sv
// rtl/present_encrypt.sv - iterative PRESENT-80 encryptor, one round per clock
//
// Purpose : rst loads msg/key and doubles as the start strobe; after release
//           ROUNDS SP rounds run, then the final key add produces enc with done=1,
//           held until the next rst.
// Ports   : clk        system clock
//           rst        synchronous active-high reset / load strobe
//           bus.key    80-bit key, sampled while rst=1
//           bus.msg    64-bit plaintext, sampled while rst=1
//           bus.done   ciphertext valid
//           bus.enc    64-bit ciphertext
module present_encrypt
    import present_pkg::*;
#(
    parameter int ROUNDS = NUM_ROUNDS
)
(
    input  logic      clk,
    input  logic      rst,
    present_if.slave  bus
);

    localparam logic [5:0] LAST = 6'(ROUNDS + 1);

    logic [BLOCK_W-1:0] state_q, state_d;
    logic [KEY_W-1:0]   kreg_q,  kreg_d;
    logic [5:0]         rcnt_q,  rcnt_d;
    logic               done_q,  done_d;
    logic [BLOCK_W-1:0] enc_q,   enc_d;

    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] sp_out;
    logic [KEY_W-1:0]   key_rot;
    logic [KEY_W-1:0]   key_upd;
    phase_e             phase;

    assign round_key = kreg_q[KEY_W-1:16];

    present_sp_layer u_sp (
        .data_i (state_q ^ round_key),
        .data_o (sp_out)
    );

    // Key schedule: rotate left 61, S-box on the top nibble, counter into bits 19:15.
    always_comb begin
        key_rot         = {kreg_q[18:0], kreg_q[79:19]};
        key_upd         = key_rot;
        key_upd[79:76]  = SBOX[key_rot[79:76]];
        key_upd[19:15]  = key_rot[19:15] ^ rcnt_q[4:0];
    end

    // done takes priority so the counter can sit at LAST forever without re-firing FIN.
    always_comb begin
        if (done_q) begin
            phase = PH_HOLD;
        end else if (rcnt_q >= LAST) begin
            phase = PH_FIN;
        end else begin
            phase = PH_RUN;
        end
    end

    always_comb begin
        state_d = state_q;
        kreg_d  = kreg_q;
        rcnt_d  = rcnt_q;
        done_d  = done_q;
        enc_d   = enc_q;
        case (phase)
            PH_RUN: begin
                state_d = sp_out;
                kreg_d  = key_upd;
                rcnt_d  = rcnt_q + 6'd1;
            end
            PH_FIN: begin
                enc_d  = state_q ^ round_key;
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= bus.msg;
            kreg_q  <= bus.key;
            rcnt_q  <= 6'd1;
            done_q  <= 1'b0;
            enc_q   <= '0;
        end else begin
            state_q <= state_d;
            kreg_q  <= kreg_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
            enc_q   <= enc_d;
        end
    end

    assign bus.done = done_q;
    assign bus.enc  = enc_q;

endmodule
